// File: rtl/dphy_tx_lane_seq.sv
// D-PHY HS transmit sequencer: orders clock-lane and data-lane requests around
// a PPI HS burst and supervises every lane-controller handshake with a timeout.
module dphy_tx_lane_seq #(
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned TCLK_PRE  = 8,
  parameter int unsigned TCLK_POST = 16,
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_tx_req_hs,
  input  logic [NUM_LANES-1:0] i_lane_enable,
  output logic                 o_tx_ready_hs,
  output logic                 o_clk_hs_req,
  input  logic                 i_clk_hs_active,
  output logic [NUM_LANES-1:0] o_data_hs_req,
  input  logic [NUM_LANES-1:0] i_data_hs_ready,
  input  logic [NUM_LANES-1:0] i_data_lp_stop,
  input  logic                 i_err_clr,
  output logic                 o_err_timeout,
  output logic                 o_busy
);

  // Counter load values: budget minus one so a timed state lasts exactly its budget.
  localparam logic [CNT_W-1:0] L_TIMEOUT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] L_PRE     = CNT_W'(TCLK_PRE - 1);
  localparam logic [CNT_W-1:0] L_POST    = CNT_W'(TCLK_POST - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLK_START,
    S_CLK_PRE,
    S_DATA_ACTIVE,
    S_DATA_END,
    S_CLK_POST,
    S_CLK_END
  } state_t;

  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [NUM_LANES-1:0] r_lane_mask;
  logic                 r_clk_hs_req;
  logic [NUM_LANES-1:0] r_data_hs_req;
  logic                 r_err_timeout;
  logic                 r_busy;

  logic w_expired;
  logic w_ready_all;
  logic w_stop_all;
  logic w_timeout;

  // Disabled lanes count as ready/stopped so only the captured mask matters.
  assign w_expired   = (r_cnt == '0);
  assign w_ready_all = &(i_data_hs_ready | ~r_lane_mask);
  assign w_stop_all  = &(i_data_lp_stop | ~r_lane_mask);

  assign w_timeout = w_expired && (
                       ((r_state == S_CLK_START) && !i_clk_hs_active) ||
                       ((r_state == S_DATA_END)  && !w_stop_all)      ||
                       ((r_state == S_CLK_END)   &&  i_clk_hs_active));

  assign o_tx_ready_hs = (r_state == S_DATA_ACTIVE) && w_ready_all;
  assign o_clk_hs_req  = r_clk_hs_req;
  assign o_data_hs_req = r_data_hs_req;
  assign o_err_timeout = r_err_timeout;
  assign o_busy        = r_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_lane_mask   <= '0;
      r_clk_hs_req  <= 1'b0;
      r_data_hs_req <= '0;
      r_busy        <= 1'b0;
    end else if (w_timeout) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_clk_hs_req  <= 1'b0;
      r_data_hs_req <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_cnt <= r_cnt - CNT_W'(1);
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (i_tx_req_hs && (|i_lane_enable)) begin
            r_state      <= S_CLK_START;
            r_lane_mask  <= i_lane_enable;
            r_cnt        <= L_TIMEOUT;
            r_clk_hs_req <= 1'b1;
            r_busy       <= 1'b1;
          end
        end
        S_CLK_START: begin
          if (i_clk_hs_active) begin
            if (i_tx_req_hs) begin
              r_state <= S_CLK_PRE;
              r_cnt   <= L_PRE;
            end else begin
              r_state <= S_CLK_POST;
              r_cnt   <= L_POST;
            end
          end
        end
        S_CLK_PRE: begin
          if (!i_tx_req_hs) begin
            r_state <= S_CLK_POST;
            r_cnt   <= L_POST;
          end else if (w_expired) begin
            r_state       <= S_DATA_ACTIVE;
            r_cnt         <= '0;
            r_data_hs_req <= r_lane_mask;
          end
        end
        S_DATA_ACTIVE: begin
          r_cnt <= '0;
          if (!i_tx_req_hs) begin
            r_state       <= S_DATA_END;
            r_cnt         <= L_TIMEOUT;
            r_data_hs_req <= '0;
          end
        end
        S_DATA_END: begin
          if (w_stop_all) begin
            r_state <= S_CLK_POST;
            r_cnt   <= L_POST;
          end
        end
        S_CLK_POST: begin
          if (w_expired) begin
            r_state      <= S_CLK_END;
            r_cnt        <= L_TIMEOUT;
            r_clk_hs_req <= 1'b0;
          end
        end
        S_CLK_END: begin
          if (!i_clk_hs_active) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state       <= S_IDLE;
          r_cnt         <= '0;
          r_clk_hs_req  <= 1'b0;
          r_data_hs_req <= '0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error: a new timeout wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_err_timeout <= 1'b1;
    end else if (i_err_clr) begin
      r_err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dphy_tx_lane_seq.sv
// Self-checking bench for dphy_tx_lane_seq: table-driven bursts plus hand-written
// abort, timeout, empty-enable and mid-burst reset sequences via a scoreboard queue.
module tb_dphy_tx_lane_seq;

  localparam int unsigned NL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          tx_req_hs;
  logic [NL-1:0] lane_enable;
  logic          tx_ready_hs;
  logic          clk_hs_req;
  logic          clk_hs_active;
  logic [NL-1:0] data_hs_req;
  logic [NL-1:0] data_hs_ready;
  logic [NL-1:0] data_lp_stop;
  logic          err_clr;
  logic          err_timeout;
  logic          busy;

  dphy_tx_lane_seq #(
    .NUM_LANES(NL), .TCLK_PRE(8), .TCLK_POST(16), .TIMEOUT(255), .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_tx_req_hs(tx_req_hs),
    .i_lane_enable(lane_enable),
    .o_tx_ready_hs(tx_ready_hs),
    .o_clk_hs_req(clk_hs_req),
    .i_clk_hs_active(clk_hs_active),
    .o_data_hs_req(data_hs_req),
    .i_data_hs_ready(data_hs_ready),
    .i_data_lp_stop(data_lp_stop),
    .i_err_clr(err_clr),
    .o_err_timeout(err_timeout),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    logic [NL-1:0] en;
    logic [NL-1:0] ready;
    logic          exp_ready;
  } vec_t;

  sb_t sb_q[$];
  int  n_pass  = 0;
  int  n_total = 0;

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string name, input logic [7:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_val(input logic [7:0] act);
    sb_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL scoreboard_empty: got %0h with nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act === e.exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    expect_val(name, exp);
    check_val(act);
  endtask

  // Full burst through every phase; lane_enable is scrambled after capture.
  task automatic run_burst(input logic [NL-1:0] en, input logic [NL-1:0] rdy,
                           input logic exp_rdy);
    lane_enable = en;
    tx_req_hs   = 1'b1;
    expect_val("clk_req_after_req", 8'd1);
    step();
    check_val(8'(clk_hs_req));
    chk("busy_after_req", 8'(busy), 8'd1);
    lane_enable = ~en;
    step(10);
    chk("data_req_clk_start", 8'(data_hs_req), 8'd0);
    clk_hs_active = 1'b1;
    step();
    step(7);
    chk("data_req_pre_7", 8'(data_hs_req), 8'd0);
    expect_val("data_req_pre_8", 8'(en));
    step();
    check_val(8'(data_hs_req));
    data_hs_ready = rdy;
    #1;
    chk("tx_ready", 8'(tx_ready_hs), 8'(exp_rdy));
    tx_req_hs = 1'b0;
    step();
    chk("data_req_end", 8'(data_hs_req), 8'd0);
    chk("tx_ready_end", 8'(tx_ready_hs), 8'd0);
    data_lp_stop = en;
    step();
    step(15);
    chk("clk_req_post_15", 8'(clk_hs_req), 8'd1);
    step();
    chk("clk_req_post_16", 8'(clk_hs_req), 8'd0);
    clk_hs_active = 1'b0;
    step();
    chk("busy_done", 8'(busy), 8'd0);
    data_hs_ready = '0;
    data_lp_stop  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic saw_data;
    vecs[0] = '{en: 4'b0011, ready: 4'b0011, exp_ready: 1'b1};
    vecs[1] = '{en: 4'b1111, ready: 4'b0111, exp_ready: 1'b0};
    vecs[2] = '{en: 4'b1111, ready: 4'b1111, exp_ready: 1'b1};
    vecs[3] = '{en: 4'b0001, ready: 4'b1110, exp_ready: 1'b0};
    vecs[4] = '{en: 4'b1000, ready: 4'b1000, exp_ready: 1'b1};
    vecs[5] = '{en: 4'b0101, ready: 4'b0100, exp_ready: 1'b0};
    vecs[6] = '{en: 4'b0110, ready: 4'b1111, exp_ready: 1'b1};
    vecs[7] = '{en: 4'b0011, ready: 4'b0001, exp_ready: 1'b0};

    rst = 1'b1; tx_req_hs = 1'b0; lane_enable = '0; clk_hs_active = 1'b0;
    data_hs_ready = '0; data_lp_stop = '0; err_clr = 1'b0;
    step(5);
    rst = 1'b0;
    step();
    chk("rst_clk_req", 8'(clk_hs_req), 8'd0);
    chk("rst_data_req", 8'(data_hs_req), 8'd0);
    chk("rst_tx_ready", 8'(tx_ready_hs), 8'd0);
    chk("rst_err", 8'(err_timeout), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);

    for (int i = 0; i < 8; i++) begin
      run_burst(vecs[i].en, vecs[i].ready, vecs[i].exp_ready);
    end

    // Abort during the clock pre-time: data lanes must never be requested.
    lane_enable = 4'b0001;
    tx_req_hs   = 1'b1;
    step();
    clk_hs_active = 1'b1;
    step();
    step(2);
    tx_req_hs = 1'b0;
    step();
    chk("abort_clk_req", 8'(clk_hs_req), 8'd1);
    saw_data = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (data_hs_req != '0) saw_data = 1'b1;
    end
    chk("abort_no_data", 8'(saw_data), 8'd0);
    chk("abort_clk_req_15", 8'(clk_hs_req), 8'd1);
    step();
    chk("abort_clk_req_16", 8'(clk_hs_req), 8'd0);
    clk_hs_active = 1'b0;
    step();
    chk("abort_busy", 8'(busy), 8'd0);

    // Clock lane never comes up; clear asserted on the timeout edge loses.
    lane_enable = 4'b1111;
    tx_req_hs   = 1'b1;
    step();
    step(254);
    chk("to_err_254", 8'(err_timeout), 8'd0);
    chk("to_clk_req_254", 8'(clk_hs_req), 8'd1);
    tx_req_hs = 1'b0;
    err_clr   = 1'b1;
    step();
    chk("to_err_255", 8'(err_timeout), 8'd1);
    chk("to_clk_req_255", 8'(clk_hs_req), 8'd0);
    chk("to_busy_255", 8'(busy), 8'd0);
    step();
    chk("err_cleared", 8'(err_timeout), 8'd0);
    err_clr = 1'b0;

    // Request with no lanes enabled is ignored.
    lane_enable = '0;
    tx_req_hs   = 1'b1;
    step(3);
    chk("noen_busy", 8'(busy), 8'd0);
    chk("noen_clk_req", 8'(clk_hs_req), 8'd0);
    chk("noen_data_req", 8'(data_hs_req), 8'd0);

    // Reset in the middle of an active burst.
    lane_enable = 4'b1111;
    step();
    clk_hs_active = 1'b1;
    step();
    step(8);
    chk("mid_data_req", 8'(data_hs_req), 8'hF);
    rst = 1'b1;
    step();
    chk("mid_rst_clk_req", 8'(clk_hs_req), 8'd0);
    chk("mid_rst_data_req", 8'(data_hs_req), 8'd0);
    chk("mid_rst_busy", 8'(busy), 8'd0);
    rst = 1'b0; tx_req_hs = 1'b0; clk_hs_active = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dphy_tx_lane_seq.md
Name: dphy_tx_lane_seq

Overview:
Top-level HS transmit sequencer for the D-PHY TX. It accepts the PPI-side HS request and drives the clock-lane controller (hs_clk_ctrl) and NUM_LANES data-lane controllers in the mandated order:
- clock lane up, then Tclk-pre, then data lanes on;
- data lanes done, then Tclk-post, then clock lane off.

It also provides timeout supervision of every handshake with the lane controllers.

Parameters:
NUM_LANES, 4, number of data lanes sequenced (1..4)
TCLK_PRE, 8, cycles between clk_hs_active seen and data_hs_req asserted (>=1)
TCLK_POST, 16, cycles between all data lanes stopped and clk_hs_req dropped (>=1)
TIMEOUT, 255, max wait cycles in any handshake state (>=1, <=255)
CNT_W, 8, width of the internal down-counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx_req_hs  in  1  PPI HS transmit request (level)
lane_enable  in  NUM_LANES  data lanes to use; sampled on leaving IDLE
tx_ready_hs  out  1  PPI ready: all enabled lanes accept HS data this cycle
clk_hs_req  out  1  request to hs_clk_ctrl
clk_hs_active  in  1  hs_active from hs_clk_ctrl
data_hs_req  out  NUM_LANES  per-lane HS request to data-lane controllers
data_hs_ready  in  NUM_LANES  per-lane ready from data-lane controllers
data_lp_stop  in  NUM_LANES  per-lane "back in LP-11 stop state"
err_clr  in  1  clears err_timeout
err_timeout  out  1  sticky handshake-timeout flag
busy  out  1  state != IDLE

Behaviour:
Reset:
- state=IDLE, lane_mask=0, counter=0.
- All outputs 0: clk_hs_req, data_hs_req, tx_ready_hs, err_timeout, busy.

Counter:
- On each state entry, load the state's cycle budget minus 1.
- Decrement every cycle while in the state; the "expired" condition is count==0.
- A timed state therefore lasts exactly its parameter value in cycles.

States and transitions:
- IDLE: if tx_req_hs && |lane_enable, capture lane_mask<=lane_enable and go to CLK_START. If lane_enable==0 the request is ignored and the block stays in IDLE.
- CLK_START: clk_hs_req=1; counter=TIMEOUT.
  - On clk_hs_active: go to CLK_PRE if tx_req_hs is high, otherwise go to CLK_POST (abort with no data).
  - On expiry: TIMEOUT path.
- CLK_PRE: clk_hs_req=1; counter=TCLK_PRE.
  - If tx_req_hs drops: go to CLK_POST immediately.
  - On expiry: go to DATA_ACTIVE.
- DATA_ACTIVE: clk_hs_req=1; data_hs_req=lane_mask.
  - tx_ready_hs = &(data_hs_ready | ~lane_mask), combinational. It is 0 in every other state.
  - On !tx_req_hs: go to DATA_END. No timeout applies in this state.
- DATA_END: clk_hs_req=1; data_hs_req=0; counter=TIMEOUT.
  - When &(data_lp_stop | ~lane_mask): go to CLK_POST.
  - On expiry: TIMEOUT path.
- CLK_POST: clk_hs_req=1; counter=TCLK_POST.
  - On expiry: go to CLK_END.
  - tx_req_hs is ignored.
- CLK_END: clk_hs_req=0; counter=TIMEOUT.
  - On !clk_hs_active: go to IDLE.
  - On expiry: TIMEOUT path.
  - A new request is accepted only from IDLE, so the minimum gap between bursts is 1 IDLE cycle.

TIMEOUT path:
- Set err_timeout, drop clk_hs_req and data_hs_req, go to IDLE the next cycle.
- err_timeout stays set until err_clr or rst. err_clr has lower priority than a new timeout in the same cycle (the flag stays 1).
- err_timeout does not block new requests.

Other rules:
- Changes to lane_enable after IDLE are ignored until the next burst.
- Outputs are registered from state. Only tx_ready_hs is combinational (state + data_hs_ready).
- rst mid-burst returns to IDLE on the next edge with all requests low. The lane controllers are reset on the same rst.

Test Plan:
- Reset: rst=1 for 5 cycles, then 0 -> all outputs 0, busy=0, state IDLE.
- Normal burst, lane_enable=4'b0011, TCLK_PRE=8:
  - tx_req_hs=1 -> clk_hs_req=1 next cycle.
  - clk_hs_active driven high 10 cycles later -> data_hs_req=4'b0011 exactly 8 cycles after active is sampled.
  - data_hs_ready=4'b0011 -> tx_ready_hs=1.
  - Drop tx_req_hs -> data_hs_req=0.
  - data_lp_stop=4'b0011 -> clk_hs_req held 16 more cycles, then 0.
  - clk_hs_active low -> busy=0.
- Partial readiness: enabled 4'b1111, data_hs_ready=4'b0111 -> tx_ready_hs=0; a disabled lane's ready (mask 0011, ready 0011) -> tx_ready_hs=1.
- Early abort: drop tx_req_hs during CLK_PRE (cycle 3 of 8) -> data_hs_req never asserts; clk_hs_req drops after 16 CLK_POST cycles.
- Timeout: hold clk_hs_active=0 after request -> at cycle 255 err_timeout=1, clk_hs_req=0, IDLE; pulse err_clr -> err_timeout=0.
- lane_enable=0 with tx_req_hs=1 -> stays IDLE, busy=0, no requests; mid-burst rst -> all requests 0 next cycle.
